// File: rtl/ad7606_pkg.sv
// -----------------------------------------------------------------------------
// ad7606_pkg
// Shared types and constants for the AD7606-family conversion sequencer.
//   state_t    : sequencer FSM states
//   OS_MAX     : highest legal oversampling code (3'b111 is invalid on the ADC)
//   DEF_*      : default parameter values for ad7606_seq
//   ch_width() : channel index width, max(1, clog2(n))
//   max_int()  : integer maximum, used to size the shared timer
//   os_clamp() : limits an oversampling request to OS_MAX
// -----------------------------------------------------------------------------
package ad7606_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_RST,
        ST_WAKE,
        ST_IDLE,
        ST_CONV,
        ST_BUSY_HI,
        ST_BUSY_LO,
        ST_RD_LO,
        ST_OUT,
        ST_RD_HI
    } state_t;

    localparam logic [2:0] OS_MAX = 3'd6;

    localparam int DEF_NUM_CH      = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_T_RESET_CYC = 3;
    localparam int DEF_T_WAKE_CYC  = 10;
    localparam int DEF_T_CONV_CYC  = 2;
    localparam int DEF_T_RD_CYC    = 2;
    localparam int DEF_T_RDH_CYC   = 1;
    localparam int DEF_T_BUSY_MAX  = 512;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [2:0] os_clamp(input logic [2:0] code);
        return (code > OS_MAX) ? OS_MAX : code;
    endfunction

endpackage

// File: rtl/ad7606_if.sv
// -----------------------------------------------------------------------------
// ad7606_if
// Sample stream between the sequencer and the downstream FIFO/DSP path.
//   valid : sample valid (master)
//   ready : sink ready (slave)
//   data  : DATA_W-bit sample, two's complement as read from the ADC
//   chan  : channel index 0..NUM_CH-1
//   last  : high together with the final channel of a frame
// Modports: master (sequencer side), slave (sink side).
// -----------------------------------------------------------------------------
interface ad7606_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   chan;
    logic              last;

    modport master (output valid, data, chan, last, input ready);
    modport slave  (input valid, data, chan, last, output ready);
endinterface

// File: rtl/ad7606_sync2.sv
// -----------------------------------------------------------------------------
// ad7606_sync2
// Two-flop synchroniser for the asynchronous ADC BUSY pin.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : synchronised output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module ad7606_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, which is what makes this a two-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ad7606_seq.sv
// -----------------------------------------------------------------------------
// ad7606_seq
// AD7606-family sequencer: powers up and resets the ADC, fires CONVST on a
// trigger, waits out BUSY, reads NUM_CH words over CS_n/RD_n and streams them
// on a valid/ready port.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   power         : 1 = ADC enabled, 0 = standby (aborts any activity)
//   trig          : single-cycle conversion request (honoured in IDLE only)
//   os_ratio      : oversampling code, latched on an accepted trig
//   clr_status    : clears the sticky status flags
//   adc_busy      : ADC BUSY pin (asynchronous)
//   adc_db        : ADC parallel data bus
//   adc_os        : ADC OS[2:0] pins
//   adc_stby_n    : ADC STBY_n
//   adc_reset     : ADC RESET
//   adc_convst_n  : ADC CONVST A/B
//   adc_cs_n      : ADC CS_n
//   adc_rd_n      : ADC RD_n
//   m             : sample stream (ad7606_if.master)
//   idle          : high in IDLE only
//   overrun       : sticky, trig seen while not IDLE
//   busy_timeout  : sticky BUSY timeout flag (only with AD7606_BUSY_TIMEOUT_EN)
//
// Build option: define AD7606_BUSY_TIMEOUT_EN to bound the BUSY wait to
// T_BUSY_MAX cycles; on expiry the ADC is re-reset and the frame is dropped.
// -----------------------------------------------------------------------------
module ad7606_seq
    import ad7606_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int T_RESET_CYC = DEF_T_RESET_CYC,
    parameter int T_WAKE_CYC  = DEF_T_WAKE_CYC,
    parameter int T_CONV_CYC  = DEF_T_CONV_CYC,
    parameter int T_RD_CYC    = DEF_T_RD_CYC,
    parameter int T_RDH_CYC   = DEF_T_RDH_CYC,
    parameter int T_BUSY_MAX  = DEF_T_BUSY_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              power,
    input  logic              trig,
    input  logic [2:0]        os_ratio,
    input  logic              clr_status,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_db,
    output logic [2:0]        adc_os,
    output logic              adc_stby_n,
    output logic              adc_reset,
    output logic              adc_convst_n,
    output logic              adc_cs_n,
    output logic              adc_rd_n,
    ad7606_if.master          m,
    output logic              idle,
    output logic              overrun
`ifdef AD7606_BUSY_TIMEOUT_EN
    ,
    output logic              busy_timeout
`endif
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int T_MAX = max_int(max_int(max_int(T_RESET_CYC, T_WAKE_CYC),
                                           max_int(T_CONV_CYC, T_RD_CYC)),
                                   max_int(T_RDH_CYC, T_BUSY_MAX));
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_load;
    logic              tmr_done;
    logic [CH_W-1:0]   ch_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_s;
    logic              busy_expired;
    logic              accept;

    logic stby_n_d, reset_d, convst_n_d, cs_n_d, rd_n_d, valid_d, idle_d;

    ad7606_sync2 u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_busy),
        .q     (busy_s)
    );

    assign tmr_done = (tmr_q == '0);
    assign accept   = valid_q && m.ready;

`ifdef AD7606_BUSY_TIMEOUT_EN
    // The shared timer is loaded on entry to BUSY_HI and keeps running through
    // BUSY_LO, so the bound covers the whole BUSY handshake.
    assign busy_expired = tmr_done;
`else
    assign busy_expired = 1'b0;
`endif

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_OFF;
        else        state_q <= state_d;
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (!power) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:     state_d = ST_RST;
                ST_RST:     if (tmr_done) state_d = ST_WAKE;
                ST_WAKE:    if (tmr_done) state_d = ST_IDLE;
                ST_IDLE:    if (trig)     state_d = ST_CONV;
                ST_CONV:    if (tmr_done) state_d = ST_BUSY_HI;
                ST_BUSY_HI: begin
                    if (busy_s)            state_d = ST_BUSY_LO;
                    else if (busy_expired) state_d = ST_RST;
                end
                ST_BUSY_LO: begin
                    if (!busy_s)           state_d = ST_RD_LO;
                    else if (busy_expired) state_d = ST_RST;
                end
                ST_RD_LO:   if (tmr_done) state_d = ST_OUT;
                ST_OUT:     if (m.ready)  state_d = (ch_q == LAST_CH) ? ST_IDLE : ST_RD_HI;
                ST_RD_HI:   if (tmr_done) state_d = ST_RD_LO;
                default:    state_d = ST_OFF;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from the next state and registered below, so the ADC pins come
    // straight from flops (no decode glitches on CONVST/RD) yet still line up
    // with the current state.
    always_comb begin
        stby_n_d   = 1'b1;
        reset_d    = 1'b0;
        convst_n_d = 1'b1;
        cs_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        valid_d    = 1'b0;
        idle_d     = 1'b0;
        case (state_d)
            ST_OFF:   stby_n_d = 1'b0;
            ST_RST:   reset_d = 1'b1;
            ST_IDLE:  idle_d = 1'b1;
            ST_CONV:  convst_n_d = 1'b0;
            ST_RD_LO: begin cs_n_d = 1'b0; rd_n_d = 1'b0; end
            ST_OUT:   begin cs_n_d = 1'b0; valid_d = 1'b1; end
            ST_RD_HI: cs_n_d = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_stby_n   <= 1'b0;
            adc_reset    <= 1'b0;
            adc_convst_n <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            valid_q      <= 1'b0;
            idle         <= 1'b0;
        end else begin
            adc_stby_n   <= stby_n_d;
            adc_reset    <= reset_d;
            adc_convst_n <= convst_n_d;
            adc_cs_n     <= cs_n_d;
            adc_rd_n     <= rd_n_d;
            valid_q      <= valid_d;
            idle         <= idle_d;
        end
    end

    // ---------------------------------------------------------------- shared timer
    // Loaded with (duration-1) on entry to a timed state; the state exits when
    // the count reaches zero, giving exactly 'duration' cycles in that state.
    always_comb begin
        tmr_load = '0;
        case (state_d)
            ST_RST:     tmr_load = TMR_W'(T_RESET_CYC - 1);
            ST_WAKE:    tmr_load = TMR_W'(T_WAKE_CYC - 1);
            ST_CONV:    tmr_load = TMR_W'(T_CONV_CYC - 1);
            ST_BUSY_HI: tmr_load = TMR_W'(T_BUSY_MAX - 1);
            ST_RD_LO:   tmr_load = TMR_W'(T_RD_CYC - 1);
            ST_RD_HI:   tmr_load = TMR_W'(T_RDH_CYC - 1);
            default:    tmr_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (state_d != state_q && state_d != ST_BUSY_LO) begin
            tmr_q <= tmr_load;
        end else if (!tmr_done) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            data_q <= '0;
            adc_os <= 3'd0;
        end else if (state_d == ST_OFF) begin
            // Abort or standby: discard any partial frame.
            ch_q   <= '0;
            data_q <= '0;
            adc_os <= 3'd0;
        end else begin
            if (state_q == ST_IDLE && trig)
                adc_os <= os_clamp(os_ratio);
            if (state_q == ST_RD_LO && tmr_done)
                data_q <= adc_db;
            if (accept)
                ch_q <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- status
    // A set in the same cycle as clr_status takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        overrun <= 1'b0;
        else if (trig && state_q != ST_IDLE) overrun <= 1'b1;
        else if (clr_status)               overrun <= 1'b0;
    end

`ifdef AD7606_BUSY_TIMEOUT_EN
    logic timeout_evt;
    assign timeout_evt = (state_q == ST_BUSY_HI || state_q == ST_BUSY_LO) && state_d == ST_RST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           busy_timeout <= 1'b0;
        else if (timeout_evt) busy_timeout <= 1'b1;
        else if (clr_status)  busy_timeout <= 1'b0;
    end
`endif

    assign m.valid = valid_q;
    assign m.data  = data_q;
    assign m.chan  = ch_q;
    assign m.last  = valid_q && (ch_q == LAST_CH);

endmodule
